// File: rtl/uart_frame_ctrl_if.sv
// rtl/uart_frame_ctrl_if.sv - receiver byte strobe in, register-write burst and frame status out
interface uart_frame_ctrl_if;
    logic [7:0] rx_byte;
    logic       rx_done;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;
    logic [2:0] state;

    modport master (
        input  rx_byte, rx_done,
        output wr_en, wr_addr, wr_data, frame_ok, frame_err, err_code, busy, state
    );

    modport slave (
        output rx_byte, rx_done,
        input  wr_en, wr_addr, wr_data, frame_ok, frame_err, err_code, busy, state
    );
endinterface

// File: rtl/uart_frame_ctrl.sv
// rtl/uart_frame_ctrl.sv - parses SYNC/ADDR/LEN/DATA[/CSUM] UART frames into register-write bursts
// UART_FRAME_CHECKSUM_EN adds the trailing CSUM byte and its check.
module uart_frame_ctrl #(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         TIMEOUT_CLKS = CLKS_PER_BIT * 20,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         MAX_LEN      = 16
) (
    input  logic              clock,
    input  logic              reset,
    uart_frame_ctrl_if.master bus
);
    localparam int               IDX_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int               GAP_W    = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CLKS - 1);
    localparam logic [8:0]       LEN_MAX  = 9'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        LEN    = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        COMMIT = 3'd5,
        DONE   = 3'd6
    } state_t;

`ifdef UART_FRAME_CHECKSUM_EN
    localparam state_t AFTER_DATA = CSUM;
`else
    localparam state_t AFTER_DATA = COMMIT;
`endif

    state_t           cur, nxt;
    logic [GAP_W-1:0] gap;
    logic [7:0]       base, frame_len, count;
    logic [7:0]       buffer [MAX_LEN];
    logic             in_frame, fail;
    logic [1:0]       fail_code;

    assign in_frame  = (cur == ADDR) || (cur == LEN) || (cur == DATA) || (cur == CSUM);
    assign bus.state = cur;

`ifdef UART_FRAME_CHECKSUM_EN
    logic [7:0] sum;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sum <= 8'd0;
        end else if (bus.rx_done) begin
            case (cur)
                ADDR:      sum <= bus.rx_byte;
                LEN, DATA: sum <= sum + bus.rx_byte;
                default:   ;
            endcase
        end
    end
`endif

    always_comb begin
        nxt       = cur;
        fail      = 1'b0;
        fail_code = 2'd0;
        case (cur)
            IDLE:   if (bus.rx_done && bus.rx_byte == SYNC_BYTE) nxt = ADDR;
            ADDR:   if (bus.rx_done) nxt = LEN;
            LEN: if (bus.rx_done) begin
                if (bus.rx_byte == 8'd0 || {1'b0, bus.rx_byte} > LEN_MAX) begin
                    nxt       = IDLE;
                    fail      = 1'b1;
                    fail_code = 2'd1;
                end else begin
                    nxt = DATA;
                end
            end
            DATA:   if (bus.rx_done && count == frame_len - 8'd1) nxt = AFTER_DATA;
`ifdef UART_FRAME_CHECKSUM_EN
            CSUM: if (bus.rx_done) begin
                if (bus.rx_byte == sum) begin
                    nxt = COMMIT;
                end else begin
                    nxt       = IDLE;
                    fail      = 1'b1;
                    fail_code = 2'd2;
                end
            end
`endif
            COMMIT: if (count == frame_len) nxt = DONE;
            DONE:   nxt = IDLE;
            default: nxt = IDLE;
        endcase
        // A byte arriving on the expiry cycle is accepted, so timeout only fires without rx_done.
        if (in_frame && !bus.rx_done && gap == GAP_LAST) begin
            nxt       = IDLE;
            fail      = 1'b1;
            fail_code = 2'd3;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cur           <= IDLE;
            gap           <= '0;
            base          <= 8'd0;
            frame_len     <= 8'd0;
            count         <= 8'd0;
            bus.wr_en     <= 1'b0;
            bus.wr_addr   <= 8'd0;
            bus.wr_data   <= 8'd0;
            bus.frame_ok  <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.err_code  <= 2'd0;
            bus.busy      <= 1'b0;
        end else begin
            cur           <= nxt;
            gap           <= (in_frame && !bus.rx_done) ? gap + 1'b1 : '0;
            bus.frame_ok  <= (nxt == DONE);
            bus.frame_err <= fail;
            bus.busy      <= (nxt != IDLE);
            bus.wr_en     <= 1'b0;
            if (fail) bus.err_code <= fail_code;
            case (cur)
                ADDR: if (bus.rx_done) base <= bus.rx_byte;
                LEN: if (bus.rx_done) begin
                    frame_len <= bus.rx_byte;
                    count     <= 8'd0;
                end
                // count doubles as the commit index, so it restarts when the payload is complete.
                DATA: if (bus.rx_done) count <= (nxt == DATA) ? count + 8'd1 : 8'd0;
                COMMIT: if (count != frame_len) begin
                    bus.wr_en   <= 1'b1;
                    bus.wr_addr <= base + count;
                    bus.wr_data <= buffer[count[IDX_W-1:0]];
                    count       <= count + 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset && cur == DATA && bus.rx_done) buffer[count[IDX_W-1:0]] <= bus.rx_byte;
    end
endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb/tb_uart_frame_ctrl.sv - randomized frame stimulus against a byte-list reference model
module tb_uart_frame_ctrl;
    localparam int         CPB  = 8;
    localparam int         TMO  = 160;
    localparam int         MAXL = 16;
    localparam logic [7:0] SYNC = 8'hA5;
`ifdef UART_FRAME_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    typedef logic [7:0] bq_t[$];

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_acc = 0;
    bit   mon_on = 1'b0;

    logic [15:0] got_w[$];
    int          got_c[$];
    int          ok_n = 0, err_n = 0, ok_cyc = 0, err_cyc = 0, viol = 0;
    logic [1:0]  err_seen = 2'd0;
    logic [15:0] exp_w[$];

    uart_frame_ctrl_if bus ();

    uart_frame_ctrl #(
        .CLKS_PER_BIT (CPB),
        .TIMEOUT_CLKS (TMO),
        .SYNC_BYTE    (SYNC),
        .MAX_LEN      (MAXL)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (mon_on) begin
            if (bus.wr_en) begin
                got_w.push_back({bus.wr_addr, bus.wr_data});
                got_c.push_back(cyc);
            end
            if (bus.frame_ok) begin
                ok_n++;
                ok_cyc = cyc;
            end
            if (bus.frame_err) begin
                err_n++;
                err_cyc  = cyc;
                err_seen = bus.err_code;
            end
            if ((bus.frame_ok && bus.frame_err) || (bus.wr_en && bus.state != 3'd5)) viol++;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Frame outcome from the byte list alone: 0 nothing, 1 committed, 2 dropped.
    task automatic model(input bq_t b, output int outcome, output int code, output int flen);
        int p = 0;
        int s;
        exp_w.delete();
        outcome = 0;
        code    = 0;
        flen    = 0;
        while (p < b.size() && b[p] != SYNC) p++;
        if (p >= b.size()) return;
        if (b.size() < p + 3) begin
            outcome = 2; code = 3; return;
        end
        flen = int'(b[p+2]);
        if (flen == 0 || flen > MAXL) begin
            outcome = 2; code = 1; return;
        end
        if (b.size() < p + 3 + flen + (CSUM_EN ? 1 : 0)) begin
            outcome = 2; code = 3; return;
        end
        s = int'(b[p+1]) + flen;
        for (int i = 0; i < flen; i++) s += int'(b[p+3+i]);
        if (CSUM_EN && int'(b[p+3+flen]) != s % 256) begin
            outcome = 2; code = 2; return;
        end
        outcome = 1;
        for (int i = 0; i < flen; i++)
            exp_w.push_back({8'((int'(b[p+1]) + i) % 256), b[p+3+i]});
    endtask

    function automatic bq_t add_csum(input bq_t b, input int delta);
        bq_t r = b;
        int  s = 0;
        for (int i = 1; i < b.size(); i++) s += int'(b[i]);
        if (CSUM_EN) r.push_back(8'(s + delta));
        return r;
    endfunction

    function automatic bq_t build(input logic [7:0] addr, input int len, input bit bad, input bit junk);
        bq_t        b;
        logic [7:0] d;
        int         s = int'(addr) + len;
        if (junk) begin
            d = 8'($urandom);
            if (d == SYNC) d = 8'h00;
            b.push_back(d);
        end
        b.push_back(SYNC);
        b.push_back(addr);
        b.push_back(8'(len));
        if (len >= 1 && len <= MAXL) begin
            for (int i = 0; i < len; i++) begin
                d = 8'($urandom);
                b.push_back(d);
                s += int'(d);
            end
            if (CSUM_EN) b.push_back(8'(s + (bad ? 1 : 0)));
        end
        return b;
    endfunction

    task automatic send_byte(input logic [7:0] d, input int gmax);
        repeat ($urandom_range(0, gmax)) @(negedge clock);
        bus.rx_byte = d;
        bus.rx_done = 1'b1;
        @(negedge clock);
        bus.rx_done = 1'b0;
        last_acc    = cyc;
    endtask

    task automatic run_frame(input string name, input bq_t b, input int gmax);
        int w0, ok0, err0, v0, outcome, code, flen, n;
        model(b, outcome, code, flen);
        w0   = got_w.size();
        ok0  = ok_n;
        err0 = err_n;
        v0   = viol;
        foreach (b[i]) send_byte(b[i], (i == 0) ? 0 : gmax);
        for (int i = 0; i < TMO + 60 && bus.busy; i++) @(negedge clock);
        repeat (2) @(negedge clock);
        check({name, "/idle"}, int'(bus.busy), 0);
        n = got_w.size() - w0;
        check({name, "/n_wr"}, n, exp_w.size());
        for (int i = 0; i < exp_w.size() && i < n; i++) begin
            check({name, "/wr"}, int'(got_w[w0+i]), int'(exp_w[i]));
            check({name, "/wr_cyc"}, got_c[w0+i], last_acc + 1 + i);
        end
        check({name, "/n_ok"}, ok_n - ok0, (outcome == 1) ? 1 : 0);
        check({name, "/n_err"}, err_n - err0, (outcome == 2) ? 1 : 0);
        if (outcome == 1 && ok_n > ok0) check({name, "/ok_cyc"}, ok_cyc, last_acc + flen + 1);
        if (outcome == 2 && err_n > err0) begin
            check({name, "/err_code"}, int'(err_seen), code);
            check({name, "/err_cyc"}, err_cyc, last_acc + ((code == 3) ? TMO : 0));
        end
        check({name, "/viol"}, viol - v0, 0);
    endtask

    initial begin
        bq_t b;
        int  ok0, w0;
        bus.rx_byte = 8'd0;
        bus.rx_done = 1'b0;
        reset       = 1'b0;
        repeat (3) @(negedge clock);
        check("rst/wr_en", int'(bus.wr_en), 0);
        check("rst/wr_addr", int'(bus.wr_addr), 0);
        check("rst/wr_data", int'(bus.wr_data), 0);
        check("rst/frame_ok", int'(bus.frame_ok), 0);
        check("rst/frame_err", int'(bus.frame_err), 0);
        check("rst/err_code", int'(bus.err_code), 0);
        check("rst/busy", int'(bus.busy), 0);
        check("rst/state", int'(bus.state), 0);
        reset  = 1'b1;
        mon_on = 1'b1;
        repeat (2) @(negedge clock);

        b = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22};
        run_frame("basic", add_csum(b, 0), 3);
        run_frame("bad_csum", add_csum(b, 1), 3);
        b = '{8'hA5, 8'h10, 8'h00};
        run_frame("len0", b, 3);
        b = '{8'hA5, 8'h10, 8'h11};
        run_frame("len17", b, 3);
        b = '{8'hA5, 8'h20, 8'h01, 8'hA5};
        run_frame("sync_as_data", add_csum(b, 0), 3);
        run_frame("max_len", build(8'h40, MAXL, 1'b0, 1'b1), 2);
        b = '{8'hA5, 8'h10};
        run_frame("timeout", b, 0);
        b = '{8'hA5, 8'hFF, 8'h02, 8'hAA, 8'hBB};
        run_frame("wrap", add_csum(b, 0), 3);

        b   = build(8'h30, 4, 1'b0, 1'b0);
        ok0 = ok_n;
        w0  = got_w.size();
        foreach (b[i]) send_byte(b[i], 2);
        for (int i = 0; i < 10 && !bus.wr_en; i++) @(negedge clock);
        check("mid_rst/first_wr", int'(bus.wr_en), 1);
        reset = 1'b0;
        @(negedge clock);
        check("mid_rst/wr_en", int'(bus.wr_en), 0);
        check("mid_rst/state", int'(bus.state), 0);
        check("mid_rst/busy", int'(bus.busy), 0);
        reset = 1'b1;
        repeat (30) @(negedge clock);
        check("mid_rst/n_ok", ok_n - ok0, 0);
        check("mid_rst/n_wr", got_w.size() - w0, 1);

        for (int k = 0; k < 40; k++) begin
            int         len, keep;
            bit         junk;
            logic [7:0] addr;
            len  = $urandom_range(0, MAXL + 2);
            junk = ($urandom_range(0, 3) == 0);
            addr = ($urandom_range(0, 3) == 0) ? 8'(8'hF0 + $urandom_range(0, 15)) : 8'($urandom);
            b    = build(addr, len, $urandom_range(0, 4) == 0, junk);
            if ($urandom_range(0, 7) == 0) begin
                keep = $urandom_range(junk ? 2 : 1, b.size() - 1);
                while (b.size() > keep) void'(b.pop_back());
            end
            run_frame($sformatf("rand%0d", k), b, 12);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
